// File: rtl/sad_min_acc.sv
// SAD accumulator with running-minimum search.
// Sums one row of absolute differences per cycle and tracks the best candidate.
module sad_min_acc #(
    parameter int PIXEL    = 8,
    parameter int LANES    = 8,
    parameter int ROWS     = 8,
    parameter int NUM_CAND = 64,
    parameter int SAD_W    = 14,
    parameter int IDX_W    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*PIXEL-1:0] abs_in,
    input  logic                   abs_valid,
    input  logic                   search_start,
    output logic [SAD_W-1:0]       sad_out,
    output logic [IDX_W-1:0]       sad_idx,
    output logic                   sad_valid,
    output logic [SAD_W-1:0]       best_sad,
    output logic [IDX_W-1:0]       best_idx,
    output logic                   search_done,
    output logic                   busy
);

    localparam int ROW_W = PIXEL + $clog2(LANES);
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_sum_d, row_sum_q;
    logic             row_v_q;
    logic [SAD_W-1:0] acc_q, acc_sum;
    logic [CNT_W-1:0] row_cnt_q;
    logic [IDX_W-1:0] cand_cnt_q;
    logic             first_q;
    logic             cand_end, last_end, better;

    // Adder tree across all lanes of the incoming row, full width.
    always_comb begin
        row_sum_d = '0;
        for (int i = 0; i < LANES; i++)
            row_sum_d = row_sum_d + ROW_W'(abs_in[i*PIXEL +: PIXEL]);
    end

    assign acc_sum  = acc_q + SAD_W'(row_sum_q);
    assign cand_end = (state_q == ACC) && row_v_q && !search_start
                      && (row_cnt_q == ROW_LAST);
    assign last_end = cand_end && (cand_cnt_q == CAND_LAST);
    assign better   = first_q || (acc_sum < best_sad);
    assign busy     = (state_q == ACC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a start pulse always (re)enters ACC; the final candidate exits.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (search_start) state_d = ACC;
            ACC: begin
                if (search_start)  state_d = ACC;
                else if (last_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: register the row sum; rows arriving with a start pulse are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sum_q <= '0;
            row_v_q   <= 1'b0;
        end else begin
            row_v_q <= 1'b0;
            if ((state_q == ACC) && abs_valid && !search_start) begin
                row_sum_q <= row_sum_d;
                row_v_q   <= 1'b1;
            end
        end
    end

    // Stage 2: accumulate rows, emit candidate SAD and update the running minimum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            row_cnt_q   <= '0;
            cand_cnt_q  <= '0;
            first_q     <= 1'b0;
            sad_out     <= '0;
            sad_idx     <= '0;
            sad_valid   <= 1'b0;
            best_sad    <= '0;
            best_idx    <= '0;
            search_done <= 1'b0;
        end else begin
            sad_valid   <= 1'b0;
            search_done <= 1'b0;
            if (search_start) begin
                acc_q      <= '0;
                row_cnt_q  <= '0;
                cand_cnt_q <= '0;
                first_q    <= 1'b1;
            end else if (cand_end) begin
                sad_out    <= acc_sum;
                sad_idx    <= cand_cnt_q;
                sad_valid  <= 1'b1;
                acc_q      <= '0;
                row_cnt_q  <= '0;
                cand_cnt_q <= last_end ? '0 : cand_cnt_q + IDX_W'(1);
                first_q    <= 1'b0;
                if (better) begin
                    best_sad <= acc_sum;
                    best_idx <= cand_cnt_q;
                end
                if (last_end) search_done <= 1'b1;
            end else if ((state_q == ACC) && row_v_q) begin
                acc_q     <= acc_sum;
                row_cnt_q <= row_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sad_min_acc.sv
// Directed bench for sad_min_acc with a four-candidate search window.
// Candidate SADs are spread over all lanes and rows; expectations are hand values.
module tb_sad_min_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] abs_in;
    logic        abs_valid;
    logic        search_start;
    logic [13:0] sad_out;
    logic [1:0]  sad_idx;
    logic        sad_valid;
    logic [13:0] best_sad;
    logic [1:0]  best_idx;
    logic        search_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int dones  = 0;
    int p0, d0;

    sad_min_acc #(
        .PIXEL(8), .LANES(8), .ROWS(8),
        .NUM_CAND(4), .SAD_W(14), .IDX_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .abs_in(abs_in), .abs_valid(abs_valid),
        .search_start(search_start),
        .sad_out(sad_out), .sad_idx(sad_idx),
        .sad_valid(sad_valid),
        .best_sad(best_sad), .best_idx(best_idx),
        .search_done(search_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sad_valid)   pulses++;
        if (search_done) dones++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    // Drive row r of a candidate whose total SAD is target, for one cycle.
    task automatic drive_row(input int target, input int r);
        int base, rem;
        base = target / 64;
        rem  = target % 64;
        for (int i = 0; i < 8; i++)
            abs_in[i*8 +: 8] = 8'(base + (((r*8 + i) < rem) ? 1 : 0));
        abs_valid = 1'b1;
        @(negedge clk);
        abs_valid = 1'b0;
        abs_in    = '0;
    endtask

    task automatic start_pulse();
        search_start = 1'b1;
        abs_valid    = 1'b1;
        abs_in       = '1;
        @(negedge clk);
        search_start = 1'b0;
        abs_valid    = 1'b0;
        abs_in       = '0;
    endtask

    task automatic send_cand(input int target, input int gap,
                             input int e_idx, input int e_done,
                             input int e_best, input int e_bidx);
        for (int r = 0; r < 8; r++) begin
            drive_row(target, r);
            chk("early", 32'(sad_valid), 0);
            if (r < 7)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_early", 32'(sad_valid), 0);
                end
        end
        @(negedge clk);
        chk("sad_valid", 32'(sad_valid), 1);
        chk("sad_out", 32'(sad_out), target);
        chk("sad_idx", 32'(sad_idx), e_idx);
        chk("search_done", 32'(search_done), e_done);
        chk("best_sad", 32'(best_sad), e_best);
        chk("best_idx", 32'(best_idx), e_bidx);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sad_out"}, 32'(sad_out), 0);
        chk({tag, "_sad_idx"}, 32'(sad_idx), 0);
        chk({tag, "_valid"}, 32'(sad_valid), 0);
        chk({tag, "_best_sad"}, 32'(best_sad), 0);
        chk({tag, "_best_idx"}, 32'(best_idx), 0);
        chk({tag, "_done"}, 32'(search_done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        abs_in       = '0;
        abs_valid    = 1'b0;
        search_start = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero rows; the start-cycle row of 255s must be discarded.
        start_pulse();
        chk("busy_start", 32'(busy), 1);
        send_cand(0, 0, 0, 0, 0, 0);
        send_cand(0, 0, 1, 0, 0, 0);
        send_cand(0, 0, 2, 0, 0, 0);
        send_cand(0, 0, 3, 1, 0, 0);
        @(negedge clk);
        chk("busy_end", 32'(busy), 0);
        chk("done_cnt", dones, 1);

        // Tie keeps the earlier index.
        start_pulse();
        send_cand(900, 0, 0, 0, 900, 0);
        send_cand(500, 0, 1, 0, 500, 1);
        send_cand(500, 0, 2, 0, 500, 1);
        send_cand(700, 0, 3, 1, 500, 1);
        @(negedge clk);
        chk("hold_best_sad", 32'(best_sad), 500);
        chk("hold_best_idx", 32'(best_idx), 1);
        chk("idle_busy", 32'(busy), 0);

        // Max SAD, then the same candidate with 3-cycle gaps.
        start_pulse();
        send_cand(16320, 0, 0, 0, 16320, 0);
        send_cand(16320, 3, 1, 0, 16320, 0);

        // Abort after 5 rows of candidate 2.
        for (int r = 0; r < 5; r++) drive_row(5000, r);
        p0 = pulses;
        d0 = dones;
        start_pulse();
        chk("abort_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        chk("abort_pulses", pulses, p0);
        chk("abort_done", dones, d0);
        send_cand(777, 0, 0, 0, 777, 0);

        // Reset mid-candidate.
        for (int r = 0; r < 3; r++) drive_row(1000, r);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        for (int r = 0; r < 8; r++) drive_row(2000, r);
        repeat (3) @(negedge clk);
        chk("postrst_pulses", pulses, p0);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_sad", 32'(sad_out), 0);
        start_pulse();
        send_cand(1234, 0, 0, 0, 1234, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
